// File: rtl/arcade_input_pkg.sv
// Shared constants for arcade_input_mux: joystick word layout, PS/2 keymap
// and the coin shaper state type.
package arcade_input_pkg;

  localparam int JB_R    = 0;
  localparam int JB_L    = 1;
  localparam int JB_D    = 2;
  localparam int JB_U    = 3;
  localparam int JB_BTN0 = 4;

  // Scancodes are 9 bits wide; bit 8 marks an E0-prefixed (extended) key.
  localparam logic [8:0] SC_P1_RIGHT   = 9'h174;
  localparam logic [8:0] SC_P1_LEFT    = 9'h16B;
  localparam logic [8:0] SC_P1_DOWN    = 9'h172;
  localparam logic [8:0] SC_P1_UP      = 9'h175;
  localparam logic [8:0] SC_P1_BTN0_A  = 9'h029;
  localparam logic [8:0] SC_P1_BTN0_B  = 9'h014;
  localparam logic [8:0] SC_P1_BTN1    = 9'h011;
  localparam logic [8:0] SC_P1_START_A = 9'h016;
  localparam logic [8:0] SC_P1_START_B = 9'h005;
  localparam logic [8:0] SC_P1_COIN    = 9'h02E;
  localparam logic [8:0] SC_P2_UP      = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN    = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT    = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT   = 9'h034;
  localparam logic [8:0] SC_P2_BTN0    = 9'h01C;
  localparam logic [8:0] SC_P2_BTN1    = 9'h01B;
  localparam logic [8:0] SC_P2_START_A = 9'h01E;
  localparam logic [8:0] SC_P2_START_B = 9'h006;
  localparam logic [8:0] SC_P2_COIN    = 9'h036;

  // Bit positions inside a keyboard latch word, independent of NUM_BUTTONS.
  localparam int KR_R     = 0;
  localparam int KR_L     = 1;
  localparam int KR_D     = 2;
  localparam int KR_U     = 3;
  localparam int KR_BTN0  = 4;
  localparam int KR_BTN1  = 5;
  localparam int KR_START = 6;
  localparam int KR_COIN  = 7;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_t;

  typedef struct packed {
    logic       hit;
    logic       player;
    logic [2:0] role;
  } key_map_t;

  function automatic key_map_t key_lookup(input logic [8:0] code);
    key_map_t m;
    m = '0;
    m.hit = 1'b1;
    case (code)
      SC_P1_RIGHT:                  m.role = 3'(KR_R);
      SC_P1_LEFT:                   m.role = 3'(KR_L);
      SC_P1_DOWN:                   m.role = 3'(KR_D);
      SC_P1_UP:                     m.role = 3'(KR_U);
      SC_P1_BTN0_A, SC_P1_BTN0_B:   m.role = 3'(KR_BTN0);
      SC_P1_BTN1:                   m.role = 3'(KR_BTN1);
      SC_P1_START_A, SC_P1_START_B: m.role = 3'(KR_START);
      SC_P1_COIN:                   m.role = 3'(KR_COIN);
      SC_P2_RIGHT:                  begin m.player = 1'b1; m.role = 3'(KR_R);     end
      SC_P2_LEFT:                   begin m.player = 1'b1; m.role = 3'(KR_L);     end
      SC_P2_DOWN:                   begin m.player = 1'b1; m.role = 3'(KR_D);     end
      SC_P2_UP:                     begin m.player = 1'b1; m.role = 3'(KR_U);     end
      SC_P2_BTN0:                   begin m.player = 1'b1; m.role = 3'(KR_BTN0);  end
      SC_P2_BTN1:                   begin m.player = 1'b1; m.role = 3'(KR_BTN1);  end
      SC_P2_START_A, SC_P2_START_B: begin m.player = 1'b1; m.role = 3'(KR_START); end
      SC_P2_COIN:                   begin m.player = 1'b1; m.role = 3'(KR_COIN);  end
      default:                      m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/coin_shaper.sv
// Turns a coin request level into a single fixed-width pulse; a new pulse
// needs the request to drop and rise again after the previous one.
//   state | meaning
//   IDLE  | waiting for a rising edge of coin_req
//   PULSE | coin_o high, counting COIN_PULSE cycles down to 0
//   HOLD  | pulse done, request still held; wait for release
module coin_shaper
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 400000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_req,
  output logic coin_o
);

  localparam int CW = $clog2(COIN_PULSE + 1);

  coin_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic          req_prev_q;
  logic          coin_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_prev_q <= 1'b0;
      coin_q     <= 1'b0;
    end else begin
      req_prev_q <= coin_req;
      case (state_q)
        IDLE: begin
          if (coin_req && !req_prev_q) begin
            state_q <= PULSE;
            cnt_q   <= CW'(COIN_PULSE - 1);
            coin_q  <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            coin_q  <= 1'b0;
            state_q <= coin_req ? HOLD : IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (!coin_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coin_o = coin_q;

endmodule

// File: rtl/arcade_input_mux.sv
// Per-player input front end: merges PS/2 keys, USB and DB9 joysticks into
// registered directions/buttons/start/coin with SOCD, autofire and coin shaping.
module arcade_input_mux
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_BUTTONS  = 2,
  parameter int COIN_PULSE   = 400000,
  parameter int AUTOFIRE_DIV = 2000000,
  parameter int COMBO_COIN   = 1
) (
  input  logic                               clk_sys,
  input  logic                               reset_n,
  input  logic [10:0]                        ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]          joy_usb,
  input  logic [16*NUM_PLAYERS-1:0]          joy_db9,
  input  logic [NUM_PLAYERS-1:0]             db9_sel,
  input  logic                               socd_en,
  input  logic [NUM_PLAYERS-1:0]             af_en,
  output logic [4*NUM_PLAYERS-1:0]           dir_out,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_out,
  output logic [NUM_PLAYERS-1:0]             start_out,
  output logic [NUM_PLAYERS-1:0]             coin_out
);

  localparam int NB      = NUM_BUTTONS;
  localparam int B_START = JB_BTN0 + NB;
  localparam int B_COIN  = JB_BTN0 + NB + 1;
  localparam int RAW_W   = B_COIN + 1;
  localparam int AF_W    = $clog2(AUTOFIRE_DIV);

  logic            old_toggle_q, old_toggle_d;
  logic [1:0][7:0] key_q, key_d;
  logic [AF_W-1:0] af_cnt_q, af_cnt_d;
  logic            af_phase_q, af_phase_d;
  key_map_t        key_hit;

  always_comb begin
    key_hit      = key_lookup(ps2_key[8:0]);
    key_d        = key_q;
    old_toggle_d = ps2_key[10];
    if ((ps2_key[10] != old_toggle_q) && key_hit.hit)
      key_d[key_hit.player][key_hit.role] = ps2_key[9];

    af_cnt_d   = af_cnt_q + 1'b1;
    af_phase_d = af_phase_q;
    if (af_cnt_q == AF_W'(AUTOFIRE_DIV - 1)) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      old_toggle_q <= ps2_key[10];
      key_q        <= '0;
      af_cnt_q     <= '0;
      af_phase_q   <= 1'b0;
    end else begin
      old_toggle_q <= old_toggle_d;
      key_q        <= key_d;
      af_cnt_q     <= af_cnt_d;
      af_phase_q   <= af_phase_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [RAW_W-1:0] joy_sel, key_word, raw;
    logic             up, down, left, right, combo, coin_req, coin_pulse;
    logic [3:0]       dir_d, dir_q;
    logic [NB-1:0]    btn_d, btn_q;
    logic             start_d, start_q, coin_d, coin_q;

    // Only P1/P2 have keyboard maps; latch bits land in the joystick layout.
    if (p < 2) begin : g_key
      always_comb begin
        key_word               = '0;
        key_word[JB_R]         = key_q[p][KR_R];
        key_word[JB_L]         = key_q[p][KR_L];
        key_word[JB_D]         = key_q[p][KR_D];
        key_word[JB_U]         = key_q[p][KR_U];
        key_word[JB_BTN0]      = key_q[p][KR_BTN0];
        if (NB > 1)
          key_word[JB_BTN0 + 1] = key_q[p][KR_BTN1];
        key_word[B_START]      = key_q[p][KR_START];
        key_word[B_COIN]       = key_q[p][KR_COIN];
      end
    end else begin : g_no_key
      assign key_word = '0;
    end

    always_comb begin
      joy_sel  = db9_sel[p] ? joy_db9[p*16 +: RAW_W] : joy_usb[p*16 +: RAW_W];
      raw      = joy_sel | key_word;
      up       = raw[JB_U] & ~(socd_en & raw[JB_D]);
      down     = raw[JB_D] & ~(socd_en & raw[JB_U]);
      left     = raw[JB_L] & ~(socd_en & raw[JB_R]);
      right    = raw[JB_R] & ~(socd_en & raw[JB_L]);
      combo    = (COMBO_COIN != 0) && raw[B_START] && raw[JB_BTN0];
      coin_req = raw[B_COIN] | combo;
      dir_d    = {up, down, left, right};
      btn_d    = raw[JB_BTN0 +: NB];
      if (af_en[p]) btn_d[0] = raw[JB_BTN0] & af_phase_q;
      // Start is hidden while it is being used as half of the coin combo.
      start_d  = raw[B_START] & ~combo;
      coin_d   = coin_pulse;
    end

    coin_shaper #(
      .COIN_PULSE(COIN_PULSE)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .coin_req(coin_req),
      .coin_o  (coin_pulse)
    );

    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        dir_q   <= '0;
        btn_q   <= '0;
        start_q <= 1'b0;
        coin_q  <= 1'b0;
      end else begin
        dir_q   <= dir_d;
        btn_q   <= btn_d;
        start_q <= start_d;
        coin_q  <= coin_d;
      end
    end

    assign dir_out[4*p +: 4]   = dir_q;
    assign btn_out[NB*p +: NB] = btn_q;
    assign start_out[p]        = start_q;
    assign coin_out[p]         = coin_q;
  end

  logic unused_inputs;
  assign unused_inputs = ^{joy_usb, joy_db9, key_q};

endmodule

// File: tb/tb_arcade_input_mux.sv
// Directed plus random stimulus for arcade_input_mux, checked every cycle
// against a behavioural model of the player-input rules.
module tb_arcade_input_mux;

  localparam int NP  = 2;
  localparam int NB  = 2;
  localparam int CP  = 5;
  localparam int AFD = 4;
  localparam int CC  = 1;
  localparam int B0  = 4;
  localparam int B1  = 5;
  localparam int BS  = 6;
  localparam int BC  = 7;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [31:0] joy_usb = '0;
  logic [31:0] joy_db9 = '0;
  logic [1:0]  db9_sel = '0;
  logic        socd_en = 1'b0;
  logic [1:0]  af_en   = '0;
  logic [7:0]  dir_out;
  logic [3:0]  btn_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mux #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .COIN_PULSE(CP),
    .AUTOFIRE_DIV(AFD), .COMBO_COIN(CC)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joy_usb(joy_usb), .joy_db9(joy_db9), .db9_sel(db9_sel),
    .socd_en(socd_en), .af_en(af_en), .dir_out(dir_out),
    .btn_out(btn_out), .start_out(start_out), .coin_out(coin_out)
  );

  // Reference model state
  logic [15:0] mkey [NP];
  logic        m_old = 1'b0;
  int          m_edges = 0;
  int          m_left [NP];
  logic        m_prev_req [NP];
  logic        m_shaper [NP];
  logic [7:0]  e_dir = '0;
  logic [3:0]  e_btn = '0;
  logic [1:0]  e_start = '0;
  logic [1:0]  e_coin = '0;

  function automatic void kmap(input logic [8:0] code, output int pl, output int bi);
    pl = 0;
    bi = -1;
    case (code)
      9'h174: bi = 0;
      9'h16B: bi = 1;
      9'h172: bi = 2;
      9'h175: bi = 3;
      9'h029, 9'h014: bi = B0;
      9'h011: bi = B1;
      9'h016, 9'h005: bi = BS;
      9'h02E: bi = BC;
      9'h034: begin pl = 1; bi = 0; end
      9'h023: begin pl = 1; bi = 1; end
      9'h02B: begin pl = 1; bi = 2; end
      9'h02D: begin pl = 1; bi = 3; end
      9'h01C: begin pl = 1; bi = B0; end
      9'h01B: begin pl = 1; bi = B1; end
      9'h01E, 9'h006: begin pl = 1; bi = BS; end
      9'h036: begin pl = 1; bi = BC; end
      default: ;
    endcase
  endfunction

  always @(posedge clk_sys) begin : model
    logic [15:0] raw;
    logic u, d, l, r, combo, req;
    int pl, bi;
    if (!reset_n) begin
      for (int p = 0; p < NP; p++) begin
        mkey[p] = '0; m_left[p] = 0; m_prev_req[p] = 1'b0; m_shaper[p] = 1'b0;
      end
      m_old = ps2_key[10];
      m_edges = 0;
      e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        raw = (db9_sel[p] ? joy_db9[p*16 +: 16] : joy_usb[p*16 +: 16]) | mkey[p];
        u = raw[3] && !(socd_en && raw[2]);
        d = raw[2] && !(socd_en && raw[3]);
        l = raw[1] && !(socd_en && raw[0]);
        r = raw[0] && !(socd_en && raw[1]);
        e_dir[p*4 +: 4] = {u, d, l, r};
        // Autofire phase flips after every AFD clocks counted since reset.
        e_btn[p*NB]     = raw[B0] && (!af_en[p] || ((m_edges / AFD) % 2 == 1));
        e_btn[p*NB + 1] = raw[B1];
        combo = (CC != 0) && raw[BS] && raw[B0];
        e_start[p] = raw[BS] && !combo;
        req = raw[BC] || combo;
        e_coin[p] = m_shaper[p];
        if (m_left[p] > 0) m_left[p]--;
        else if (req && !m_prev_req[p]) m_left[p] = CP;
        m_shaper[p] = (m_left[p] > 0);
        m_prev_req[p] = req;
      end
      kmap(ps2_key[8:0], pl, bi);
      if (ps2_key[10] != m_old && bi >= 0) mkey[pl][bi] = ps2_key[9];
      m_old = ps2_key[10];
      m_edges++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("dir_model", 32'(dir_out), 32'(e_dir));
    check("btn_model", 32'(btn_out), 32'(e_btn));
    check("start_model", 32'(start_out), 32'(e_start));
    check("coin_model", 32'(coin_out), 32'(e_coin));
  endtask

  task automatic key_event(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  logic [8:0] codes [12] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h011,
                             9'h02E, 9'h02D, 9'h034, 9'h01C, 9'h036, 9'h01D};

  initial begin : stim
    int cnt_coin, cnt_start, rise1, rise2;
    logic prev_b;

    reset_n = 1'b0;
    repeat (3) cycle();
    check("reset_dir", 32'(dir_out), 32'h0);
    check("reset_coin", 32'(coin_out), 32'h0);
    reset_n = 1'b1;
    cycle();

    // Keyboard: two-cycle latency, same-toggle ignored, release clears.
    key_event(1'b1, 9'h175);
    cycle();
    check("key_lat1", 32'(dir_out[3]), 32'h0);
    cycle();
    check("key_up", 32'(dir_out[3]), 32'h1);
    ps2_key[9] = 1'b0;
    repeat (2) cycle();
    check("key_same_toggle", 32'(dir_out[3]), 32'h1);
    key_event(1'b0, 9'h175);
    repeat (2) cycle();
    check("key_release", 32'(dir_out[3]), 32'h0);
    key_event(1'b1, 9'h02D);
    repeat (2) cycle();
    check("key_p2_up", 32'(dir_out[7]), 32'h1);
    key_event(1'b0, 9'h02D);
    repeat (2) cycle();

    // Source select
    joy_usb[15:0] = 16'h0001;
    joy_db9[15:0] = 16'h0002;
    cycle();
    check("sel_usb", 32'(dir_out[3:0]), 32'h1);
    db9_sel[0] = 1'b1;
    cycle();
    check("sel_db9", 32'(dir_out[3:0]), 32'h2);
    db9_sel[0] = 1'b0;

    // SOCD
    joy_usb[15:0] = 16'h000C;
    socd_en = 1'b1;
    cycle();
    check("socd_on", 32'(dir_out[3:0]), 32'h0);
    socd_en = 1'b0;
    cycle();
    check("socd_off", 32'(dir_out[3:0]), 32'hC);
    joy_usb = '0;
    joy_db9 = '0;
    repeat (2) cycle();

    // Coin held 20 cycles, then re-press, then a press during the pulse.
    cnt_coin = 0;
    joy_usb[BC] = 1'b1;
    repeat (20) begin cycle(); cnt_coin += coin_out[0]; end
    check("coin_hold_len", 32'(cnt_coin), 32'd5);
    joy_usb[BC] = 1'b0;
    repeat (3) cycle();
    cnt_coin = 0;
    joy_usb[BC] = 1'b1;
    repeat (12) begin cycle(); cnt_coin += coin_out[0]; end
    check("coin_repress_len", 32'(cnt_coin), 32'd5);
    joy_usb[BC] = 1'b0;
    repeat (3) cycle();
    cnt_coin = 0;
    joy_usb[BC] = 1'b1;
    repeat (2) begin cycle(); cnt_coin += coin_out[0]; end
    joy_usb[BC] = 1'b0;
    cycle(); cnt_coin += coin_out[0];
    joy_usb[BC] = 1'b1;
    repeat (17) begin cycle(); cnt_coin += coin_out[0]; end
    check("coin_no_retrigger", 32'(cnt_coin), 32'd5);
    joy_usb = '0;
    repeat (4) cycle();

    // Combo coin and plain start
    cnt_coin = 0; cnt_start = 0;
    joy_usb[15:0] = 16'h0050;
    repeat (15) begin cycle(); cnt_coin += coin_out[0]; cnt_start += start_out[0]; end
    check("combo_coin_len", 32'(cnt_coin), 32'd5);
    check("combo_start_hidden", 32'(cnt_start), 32'd0);
    joy_usb = '0;
    repeat (3) cycle();
    cnt_coin = 0; cnt_start = 0;
    joy_usb[15:0] = 16'h0040;
    repeat (8) begin cycle(); cnt_coin += coin_out[0]; cnt_start += start_out[0]; end
    check("start_only_start", 32'(cnt_start), 32'd8);
    check("start_only_coin", 32'(cnt_coin), 32'd0);
    joy_usb = '0;
    cycle();

    // Autofire period
    af_en[0] = 1'b1;
    joy_usb[B0] = 1'b1;
    rise1 = -1; rise2 = -1; prev_b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (btn_out[0] && !prev_b) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_b = btn_out[0];
    end
    check("af_period", 32'(rise2 - rise1), 32'd8);

    // Reset in the middle of a coin pulse with inputs held
    joy_usb[15:0] = 16'h0081;
    repeat (3) cycle();
    check("pre_reset_coin", 32'(coin_out[0]), 32'h1);
    reset_n = 1'b0;
    cycle();
    check("mid_reset_dir", 32'(dir_out), 32'h0);
    check("mid_reset_btn", 32'(btn_out), 32'h0);
    check("mid_reset_coin", 32'(coin_out), 32'h0);
    check("mid_reset_start", 32'(start_out), 32'h0);
    reset_n = 1'b1;
    af_en = '0;
    joy_usb = '0;
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) joy_usb = $urandom & $urandom & 32'h00FF_00FF;
      if ($urandom_range(0, 3) == 0) joy_db9 = $urandom & $urandom & 32'h00FF_00FF;
      if ($urandom_range(0, 15) == 0) db9_sel = 2'($urandom);
      if ($urandom_range(0, 15) == 0) af_en = 2'($urandom);
      if ($urandom_range(0, 15) == 0) socd_en = 1'($urandom);
      if ($urandom_range(0, 3) == 0)
        key_event(1'($urandom), codes[$urandom_range(0, 11)]);
      else if ($urandom_range(0, 7) == 0)
        ps2_key[8:0] = codes[$urandom_range(0, 11)];
      reset_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
